pb_spi_multi: RTL and testbench

PB_SPI_MULTI -- requirements
Module: pb_spi_multi

---
 rtl/pb_spi_multi.sv | 255 +++++++++++++++++++++++++
 tb/tb_pb_spi_multi.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_spi_multi.sv
// Picoblaze-attached SPI master with multiple chip selects, TX/RX FIFOs,
// programmable SCK divider, CPOL/CPHA/bit-order control and sticky status flags.
module pb_spi_multi #(
  parameter logic [7:0]  BASE_ADDRESS = 8'h00,
  parameter int unsigned NUM_CS       = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        port_id,
  input  logic [7:0]        data_in,
  input  logic              read_strobe,
  input  logic              write_strobe,
  output logic [7:0]        data_out,
  output logic              interrupt,
  output logic              sck_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] ncs_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLead, StShift, StTrail} state_e;

  // Address decode relative to the base port
  logic [7:0] offset;
  logic       sel_ctrl, sel_div, sel_cssel, sel_status, sel_data;
  assign offset     = port_id - BASE_ADDRESS;
  assign sel_ctrl   = (offset == 8'd0);
  assign sel_div    = (offset == 8'd1);
  assign sel_cssel  = (offset == 8'd2);
  assign sel_status = (offset == 8'd3);
  assign sel_data   = (offset == 8'd4);

  // Control registers and sticky flags
  logic [5:0] ctrl_q;
  logic [7:0] div_q;
  logic [2:0] cs_idx_q;
  logic       mancs_q;
  logic       wcol_q, done_q, rovr_q;

  // FIFO storage and pointers
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop;

  // Shift engine
  state_e     state_q, state_d;
  logic [7:0] hcnt_q, div_l_q, tx_sr_q, rx_sr_q;
  logic [3:0] hidx_q, nidx;
  logic       mosi_q, cpol_l_q, cpha_l_q, lsbf_l_q;
  logic       half_end, load, adv, byte_end, lead_edge, trail_edge, shift_out, sample;
  logic       busy;
  logic [7:0] tx_head;

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_push  = write_strobe & sel_data & ~tx_full;
  assign rx_pop   = read_strobe & sel_data & ~rx_empty;
  assign rx_push  = byte_end & ~rx_full;
  assign tx_head  = tx_mem[tx_rd_q];
  assign busy     = (state_q != StIdle);
  assign half_end = (hcnt_q == div_l_q);

  // Register writes and sticky flags; a set event wins over a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= '0;
      div_q    <= '0;
      cs_idx_q <= '0;
      mancs_q  <= 1'b0;
      wcol_q   <= 1'b0;
      done_q   <= 1'b0;
      rovr_q   <= 1'b0;
    end else begin
      if (write_strobe && sel_ctrl) ctrl_q <= data_in[5:0];
      if (write_strobe && sel_div) div_q <= data_in;
      if (write_strobe && sel_cssel) begin
        cs_idx_q <= data_in[2:0];
        mancs_q  <= data_in[7];
      end
      wcol_q <= (wcol_q & ~(write_strobe & sel_status & data_in[7]))
                | (write_strobe & sel_data & tx_full);
      done_q <= (done_q & ~(write_strobe & sel_status & data_in[6])) | byte_end;
      rovr_q <= (rovr_q & ~(write_strobe & sel_status & data_in[5])) | (byte_end & rx_full);
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= data_in;
    if (rx_push) rx_mem[rx_wr_q] <= rx_sr_q;
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
      if (tx_push && !tx_pop) tx_cnt_q <= tx_cnt_q + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
      if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
      if (rx_push && !rx_pop) rx_cnt_q <= rx_cnt_q + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
    end
  end

  // Engine state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Engine next state; clearing EN aborts from any active state
  always_comb begin
    state_d  = state_q;
    tx_pop   = 1'b0;
    load     = 1'b0;
    adv      = 1'b0;
    byte_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_q[0] && !tx_empty) begin
          state_d = StLead;
          tx_pop  = 1'b1;
          load    = 1'b1;
        end
      end
      StLead: begin
        if (!ctrl_q[0]) state_d = StIdle;
        else if (half_end) begin
          state_d = StShift;
          adv     = 1'b1;
        end
      end
      StShift: begin
        if (!ctrl_q[0]) state_d = StIdle;
        else if (half_end) begin
          if (hidx_q == 4'd15) begin
            byte_end = 1'b1;
            if (!tx_empty) begin
              state_d = StLead;
              tx_pop  = 1'b1;
              load    = 1'b1;
            end else begin
              state_d = StTrail;
            end
          end else begin
            adv = 1'b1;
          end
        end
      end
      StTrail: begin
        if (!ctrl_q[0] || half_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Even half-period index follows a leading SCK edge, odd one a trailing edge
  assign nidx       = (state_q == StLead) ? 4'd0 : hidx_q + 4'd1;
  assign lead_edge  = adv & ~nidx[0];
  assign trail_edge = adv & nidx[0];
  assign shift_out  = cpha_l_q ? lead_edge : trail_edge;
  assign sample     = cpha_l_q ? trail_edge : lead_edge;

  // Engine datapath: half-period timer, shift registers, latched byte config
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q   <= '0;
      hidx_q   <= '0;
      div_l_q  <= '0;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      mosi_q   <= 1'b0;
      cpol_l_q <= 1'b0;
      cpha_l_q <= 1'b0;
      lsbf_l_q <= 1'b0;
    end else begin
      if (state_q == StIdle || half_end || state_d == StIdle) hcnt_q <= '0;
      else hcnt_q <= hcnt_q + 8'd1;
      if (load) begin
        cpol_l_q <= ctrl_q[1];
        cpha_l_q <= ctrl_q[2];
        lsbf_l_q <= ctrl_q[3];
        div_l_q  <= div_q;
        hidx_q   <= '0;
        rx_sr_q  <= '0;
        if (!ctrl_q[2]) begin
          // CPHA=0 presents the first bit before the first edge
          mosi_q  <= ctrl_q[3] ? tx_head[0] : tx_head[7];
          tx_sr_q <= ctrl_q[3] ? {1'b0, tx_head[7:1]} : {tx_head[6:0], 1'b0};
        end else begin
          tx_sr_q <= tx_head;
        end
      end else begin
        if (adv) hidx_q <= nidx;
        if (shift_out) begin
          mosi_q  <= lsbf_l_q ? tx_sr_q[0] : tx_sr_q[7];
          tx_sr_q <= lsbf_l_q ? {1'b0, tx_sr_q[7:1]} : {tx_sr_q[6:0], 1'b0};
        end
        if (sample) rx_sr_q <= lsbf_l_q ? {miso_i, rx_sr_q[7:1]} : {rx_sr_q[6:0], miso_i};
      end
    end
  end

  // SCK level: idles at live CPOL, toggles once per half-period while shifting
  always_comb begin
    sck_o = ctrl_q[1];
    unique case (state_q)
      StIdle:          sck_o = ctrl_q[1];
      StLead, StTrail: sck_o = cpol_l_q;
      StShift:         sck_o = cpol_l_q ^ ~hidx_q[0];
      default:         sck_o = ctrl_q[1];
    endcase
  end

  assign mosi_o    = mosi_q;
  assign interrupt = ctrl_q[4] & ((done_q & tx_empty & ~busy) | rovr_q);

  // Chip selects: only the indexed line may go low
  always_comb begin
    for (int i = 0; i < NUM_CS; i++) begin
      ncs_o[i] = ~((cs_idx_q == 3'(i)) & (mancs_q | (ctrl_q[5] & busy)));
    end
  end

  // Register read mux
  always_comb begin
    data_out = 8'h00;
    if (sel_ctrl)   data_out = {2'b00, ctrl_q};
    if (sel_div)    data_out = div_q;
    if (sel_cssel)  data_out = {mancs_q, 4'b0000, cs_idx_q};
    if (sel_status) data_out = {wcol_q, done_q, rovr_q, rx_full, rx_empty,
                                tx_empty, tx_full, busy};
    if (sel_data && !rx_empty) data_out = rx_mem[rx_rd_q];
  end

endmodule

// File: tb/tb_pb_spi_multi.sv
// Bench for pb_spi_multi: directed register/transfer scenarios, a byte-level
// timeline model checked every cycle, and hand-computed literal expectations.
module tb_pb_spi_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id, data_in, data_out;
  logic       read_strobe, write_strobe;
  logic       interrupt, sck_o, mosi_o, miso_i;
  logic [3:0] ncs_o;

  int total = 0;
  int bad   = 0;

  // MOSI looped back to MISO: every received byte equals the transmitted one
  assign miso_i = mosi_o;

  pb_spi_multi dut (
    .clk         (clk),
    .reset       (reset),
    .port_id     (port_id),
    .data_in     (data_in),
    .read_strobe (read_strobe),
    .write_strobe(write_strobe),
    .data_out    (data_out),
    .interrupt   (interrupt),
    .sck_o       (sck_o),
    .mosi_o      (mosi_o),
    .miso_i      (miso_i),
    .ncs_o       (ncs_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] q_tx[$];
  logic [7:0] q_rx[$];
  logic [7:0] m_ctrl = 0, m_div = 0, m_cssel = 0, m_byte = 0;
  bit         m_wcol = 0, m_done = 0, m_rovr = 0, m_busy = 0, m_trail = 0;
  bit         c_cpol = 0, c_cpha = 0, c_lsbf = 0;
  int         m_c = 0, c_d = 1;

  task automatic start_byte();
    m_byte  = q_tx.pop_front();
    c_cpol  = m_ctrl[1];
    c_cpha  = m_ctrl[2];
    c_lsbf  = m_ctrl[3];
    c_d     = int'(m_div) + 1;
    m_c     = 0;
    m_busy  = 1;
    m_trail = 0;
  endtask

  // One clock edge of the model: a byte is LEAD + 16 half-periods, d cycles each
  task automatic model_step();
    bit txf, rxf, sd, sr, sw;
    if (reset) begin
      q_tx.delete(); q_rx.delete();
      m_ctrl = 0; m_div = 0; m_cssel = 0;
      m_wcol = 0; m_done = 0; m_rovr = 0; m_busy = 0; m_trail = 0; m_c = 0;
      return;
    end
    txf = (q_tx.size() == 4);
    rxf = (q_rx.size() == 4);
    sd = 0; sr = 0; sw = 0;
    if (read_strobe && port_id == 8'd4 && q_rx.size() > 0) void'(q_rx.pop_front());
    if (m_busy && !m_ctrl[0]) m_busy = 0;
    else if (!m_busy) begin
      if (m_ctrl[0] && q_tx.size() > 0) start_byte();
    end else if (m_trail) begin
      m_c++;
      if (m_c == c_d) m_busy = 0;
    end else begin
      m_c++;
      if (m_c == 17 * c_d) begin
        sd = 1;
        if (rxf) sr = 1;
        else q_rx.push_back(m_byte);
        if (q_tx.size() > 0) start_byte();
        else begin
          m_trail = 1;
          m_c = 0;
        end
      end
    end
    if (write_strobe) begin
      case (port_id)
        8'd0: m_ctrl = data_in & 8'h3F;
        8'd1: m_div = data_in;
        8'd2: m_cssel = data_in & 8'h87;
        8'd3: begin
          if (data_in[7]) m_wcol = 0;
          if (data_in[6]) m_done = 0;
          if (data_in[5]) m_rovr = 0;
        end
        8'd4: begin
          if (txf) sw = 1;
          else q_tx.push_back(data_in);
        end
        default: ;
      endcase
    end
    if (sw) m_wcol = 1;
    if (sd) m_done = 1;
    if (sr) m_rovr = 1;
  endtask

  always @(posedge clk) model_step();

  function automatic logic exp_sck();
    int h;
    if (!m_busy) return m_ctrl[1];
    if (m_trail) return c_cpol;
    h = m_c / c_d;
    if (h == 0) return c_cpol;
    return (((h - 1) % 2) == 0) ? !c_cpol : c_cpol;
  endfunction

  function automatic logic [3:0] exp_ncs();
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++)
      if (int'(m_cssel[2:0]) == i && (m_cssel[7] || (m_ctrl[5] && m_busy))) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic exp_irq();
    return m_ctrl[4] && ((m_done && q_tx.size() == 0 && !m_busy) || m_rovr);
  endfunction

  function automatic logic [7:0] exp_status();
    return {m_wcol, m_done, m_rovr, q_rx.size() == 4, q_rx.size() == 0,
            q_tx.size() == 0, q_tx.size() == 4, m_busy};
  endfunction

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    case (a)
      8'd0: return m_ctrl;
      8'd1: return m_div;
      8'd2: return m_cssel;
      8'd3: return exp_status();
      8'd4: return (q_rx.size() > 0) ? q_rx[0] : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- edge monitor ----------------
  bit cnt_clr = 0;
  int rise_cnt = 0, fall_cnt = 0, cs_fall = 0, cyc = 0, r1 = 0, r2 = 0;
  logic sck_prev = 0, cs_prev = 1;

  always @(negedge clk) begin
    cyc++;
    if (cnt_clr) begin
      rise_cnt = 0; fall_cnt = 0; cs_fall = 0;
    end else begin
      if (sck_o && !sck_prev) begin
        rise_cnt++;
        if (rise_cnt == 1) r1 = cyc;
        if (rise_cnt == 2) r2 = cyc;
      end
      if (!sck_o && sck_prev) fall_cnt++;
      if (!ncs_o[0] && cs_prev) cs_fall++;
    end
    sck_prev = sck_o;
    cs_prev  = ncs_o[0];
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic per_cycle();
    int h, k;
    chk("sck", sck_o, exp_sck());
    chk("ncs", ncs_o, exp_ncs());
    chk("irq", interrupt, exp_irq());
    if (m_busy && !m_trail && !reset) begin
      h = m_c / c_d;
      k = -1;
      if (!c_cpha && h <= 15) k = h / 2;
      if (c_cpha && h >= 1) k = (h - 1) / 2;
      if (k >= 0) chk("mosi", mosi_o, c_lsbf ? m_byte[k] : m_byte[7 - k]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a; data_in = d; write_strobe = 1'b1;
    idle(1);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input string name, input bit use_lit,
                    input logic [7:0] lit);
    port_id = a; read_strobe = 1'b1;
    #2;
    chk({name, "_model"}, data_out, exp_rd(a));
    if (use_lit) chk(name, data_out, lit);
    idle(1);
    read_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_busy || q_tx.size() != 0) && n < 3000) begin
      idle(1);
      n++;
    end
    chk({name, "_timeout"}, n >= 3000, 0);
  endtask

  task automatic clr_cnt();
    cnt_clr = 1;
    idle(1);
    cnt_clr = 0;
  endtask

  task automatic rst_outputs(input string name);
    chk({name, "_sck"}, sck_o, 1'b0);
    chk({name, "_mosi"}, mosi_o, 1'b0);
    chk({name, "_ncs"}, ncs_o, 4'hF);
    chk({name, "_irq"}, interrupt, 1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b1; port_id = 0; data_in = 0; read_strobe = 0; write_strobe = 0;
    fork
      forever begin
        @(negedge clk);
        per_cycle();
      end
    join_none
    #1;
    idle(2);
    rst_outputs("in_reset");
    rd(8'd3, "rst_status", 1, 8'h0C);
    reset = 1'b0;
    idle(1);
    rst_outputs("post_reset");
    rd(8'd0, "rst_ctrl", 1, 8'h00);
    rd(8'd1, "rst_div", 1, 8'h00);
    rd(8'h10, "unmapped", 1, 8'h00);

    // Single byte, DIV=1, AUTOCS on CS0
    wr(8'd1, 8'd1);
    wr(8'd2, 8'd0);
    wr(8'd0, 8'h21);
    rd(8'd0, "ctrl_rb", 1, 8'h21);
    clr_cnt();
    wr(8'd4, 8'hA5);
    wait_idle("t1");
    chk("t1_sck_pulses", rise_cnt, 8);
    chk("t1_sck_period", r2 - r1, 4);
    chk("t1_cs_falls", cs_fall, 1);
    rd(8'd3, "t1_status", 1, 8'h44);
    rd(8'd4, "t1_rx", 1, 8'hA5);
    rd(8'd3, "t1_status2", 1, 8'h4C);

    // Four-byte burst, CPOL=1 CPHA=1, CS held low throughout
    wr(8'd3, 8'hE0);
    wr(8'd0, 8'h27);
    idle(2);
    chk("t2_sck_idle_high", sck_o, 1'b1);
    clr_cnt();
    wr(8'd4, 8'h11);
    wr(8'd4, 8'h22);
    wr(8'd4, 8'h33);
    wr(8'd4, 8'h44);
    wait_idle("t2");
    chk("t2_cs_falls", cs_fall, 1);
    chk("t2_sck_lead_edges", fall_cnt, 32);
    chk("t2_sck_end_high", sck_o, 1'b1);
    rd(8'd4, "t2_rx0", 1, 8'h11);
    rd(8'd4, "t2_rx1", 1, 8'h22);
    rd(8'd4, "t2_rx2", 1, 8'h33);
    rd(8'd4, "t2_rx3", 1, 8'h44);

    // TX overflow with engine disabled
    wr(8'd3, 8'hE0);
    wr(8'd0, 8'h20);
    wr(8'd4, 8'h51);
    wr(8'd4, 8'h52);
    wr(8'd4, 8'h53);
    wr(8'd4, 8'h54);
    wr(8'd4, 8'h55);
    rd(8'd3, "t3_wcol", 1, 8'h8A);
    wr(8'd3, 8'h80);
    rd(8'd3, "t3_wcol_clr", 1, 8'h0A);
    wr(8'd0, 8'h21);
    wait_idle("t3");
    rd(8'd4, "t3_rx0", 1, 8'h51);
    rd(8'd4, "t3_rx1", 1, 8'h52);
    rd(8'd4, "t3_rx2", 1, 8'h53);
    rd(8'd4, "t3_rx3", 1, 8'h54);
    rd(8'd3, "t3_no_fifth", 1, 8'h4C);

    // RX overrun with interrupt enabled
    wr(8'd3, 8'hE0);
    wr(8'd0, 8'h31);
    wr(8'd4, 8'hA1);
    wr(8'd4, 8'hA2);
    wr(8'd4, 8'hA3);
    wr(8'd4, 8'hA4);
    wr(8'd4, 8'hA5);
    wait_idle("t4");
    chk("t4_irq", interrupt, 1'b1);
    rd(8'd3, "t4_status", 1, 8'h74);
    rd(8'd4, "t4_rx0", 1, 8'hA1);
    rd(8'd4, "t4_rx1", 1, 8'hA2);
    rd(8'd4, "t4_rx2", 1, 8'hA3);
    rd(8'd4, "t4_rx3", 1, 8'hA4);
    rd(8'd3, "t4_status2", 1, 8'h6C);
    wr(8'd3, 8'hE0);
    idle(1);
    chk("t4_irq_clr", interrupt, 1'b0);

    // CS2, LSB first
    wr(8'd2, 8'h02);
    wr(8'd0, 8'h29);
    wr(8'd4, 8'h01);
    n = 0;
    while (ncs_o == 4'hF && n < 20) begin
      idle(1);
      n++;
    end
    chk("t5_ncs", ncs_o, 4'b1011);
    chk("t5_first_mosi", mosi_o, 1'b1);
    wait_idle("t5");
    rd(8'd4, "t5_rx", 1, 8'h01);

    // Abort by clearing EN, then reset mid-transfer
    wr(8'd2, 8'h00);
    wr(8'd3, 8'hE0);
    wr(8'd1, 8'd3);
    wr(8'd0, 8'h23);
    wr(8'd4, 8'hC3);
    idle(20);
    wr(8'd0, 8'h22);
    idle(3);
    chk("t6_abort_sck", sck_o, 1'b1);
    rd(8'd3, "t6_abort_status", 1, 8'h0C);
    wr(8'd0, 8'h23);
    wr(8'd4, 8'h5A);
    idle(15);
    reset = 1'b1;
    #1;
    rst_outputs("t6_in_reset");
    idle(1);
    rd(8'd3, "t6_rst_status", 1, 8'h0C);
    reset = 1'b0;
    idle(2);
    rst_outputs("t6_after_reset");
    rd(8'd3, "t6_status", 1, 8'h0C);
    rd(8'd0, "t6_ctrl", 1, 8'h00);
    rd(8'd1, "t6_div", 1, 8'h00);
    rd(8'd2, "t6_cssel", 1, 8'h00);
    rd(8'd4, "t6_data", 1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
